hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Parametrised hazard/stall controller for the 5-stage MIPS pipeline with branch resolution in ID.
- Detects load-use and branch-operand data hazards, freezes the pipe on data-memory wait and issues IF/ID flush on taken branches.
- Adds a stall-tracking FSM, saturating performance counters and a sticky stall-timeout flag.
- Sits beside the ID stage; drives the PC, IF/ID and ID/EX write/bubble controls and a global freeze.

Parameters:
- REG_AW, 5, register-address width.
- OPC_W, 6, opcode width.
- BEQ_OPC, 6'b000100, branch-equal opcode.
- BNE_OPC, 6'b000101, branch-not-equal opcode.
- BR_FWD_EXMEM, 1, 1 = ALU results in EX/MEM are forwarded to ID (only loads there stall a branch); 0 = any EX/MEM register write stalls a branch.
- CNT_W, 16, performance counter width.
- MAX_STALL, 8, consecutive non-RUN cycles that set stall_err.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- opc_id  in  OPC_W  opcode in ID.
- funct_id  in  6  funct field in ID; used only with JR_HAZARD_EN.
- rs_id, rt_id  in  REG_AW  source registers in ID.
- rt_used_id  in  1  instruction in ID reads rt.
- dst_idex  in  REG_AW  final destination register in ID/EX.
- regwrite_idex, memread_idex  in  1  ID/EX controls.
- dst_exmem  in  REG_AW  final destination register in EX/MEM.
- regwrite_exmem, memread_exmem  in  1  EX/MEM controls.
- branch_taken_id  in  1  branch resolved taken in ID.
- mem_busy  in  1  data memory not ready.
- cnt_clr  in  1  synchronous clear of counters and stall_err.
- pc_write, ifid_write  out  1  enables; 0 = hold.
- hazard_source  out  1  1 = pass ID controls to ID/EX; 0 = insert bubble.
- pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB.
- ifid_flush  out  1  zero IF/ID.
- state  out  2  FSM state.
- stall_cnt, mem_cnt, flush_cnt  out  CNT_W  counters.
- stall_err  out  1  sticky timeout.

Behaviour:
- Match rules:
  - m(r) = (r != 0) && (r == rs_id || (rt_used_id && r == rt_id)).
  - Register 0 never creates a hazard.
- Hazard terms:
  - is_br = opc_id == BEQ_OPC || opc_id == BNE_OPC.
  - load_use = memread_idex && m(dst_idex).
  - br_haz = is_br && ((regwrite_idex && m(dst_idex)) || (memread_exmem && m(dst_exmem)) || (!BR_FWD_EXMEM && regwrite_exmem && m(dst_exmem))).
  - dstall = load_use || br_haz.
  - A load feeding a branch therefore stalls 2 cycles.
- Outputs are combinational, same cycle, with priority freeze > dstall > flush:
  - mem_busy: pipe_freeze=1, pc_write=0, ifid_write=0, hazard_source=1, ifid_flush=0.
  - else dstall: pc_write=0, ifid_write=0, hazard_source=0, pipe_freeze=0, ifid_flush=0.
  - else branch_taken_id: ifid_flush=1, pc_write=1, ifid_write=1, hazard_source=1.
  - else: pc_write=1, ifid_write=1, hazard_source=1, all others 0.
- A taken branch held during freeze or stall flushes on the first cycle neither applies.
- FSM, registered, encoding RUN=0, DSTALL=1, MWAIT=2:
  - Next state is MWAIT if mem_busy, else DSTALL if dstall, else RUN; evaluated from every state.
- run_len counter:
  - Counts consecutive cycles whose next state is not RUN; clears when next state is RUN.
  - When it reaches MAX_STALL, stall_err is set and held until rst or cnt_clr.
- Counters:
  - stall_cnt +1 per cycle with dstall && !mem_busy.
  - mem_cnt +1 per mem_busy cycle.
  - flush_cnt +1 per ifid_flush cycle.
  - All saturate at 2^CNT_W-1.
  - cnt_clr has priority over increment in the same cycle.
- Reset:
  - state=RUN; counters, run_len and stall_err = 0.
  - Combinational outputs follow inputs during reset.
  - Reset mid-stall returns to RUN on the next edge.

Optional Feature:
- Macro JR_HAZARD_EN.
- Defined: opc_id==0 && funct_id==6'b001000 (jr) is treated as is_br with rt ignored; jr never raises ifid_flush via the hazard rules.
- Undefined: funct_id is ignored and jr is handled as an ordinary R-type.

Test Plan:
- Load-use: memread_idex=1, dst_idex=8, rs_id=8 -> pc_write=0, ifid_write=0, hazard_source=0, state=DSTALL next edge, stall_cnt=1.
- Zero register: memread_idex=1, dst_idex=0, rs_id=0 -> no stall, all enables 1.
- Load-then-beq: lw $9 in ID/EX, beq $9,$0 in ID -> two stall cycles (ID/EX then EX/MEM match), stall_cnt=2, then branch_taken_id=1 -> ifid_flush=1 for one cycle, flush_cnt=1.
- BR_FWD_EXMEM=0: regwrite_exmem=1, dst_exmem=4, beq rs=4 -> stall; with BR_FWD_EXMEM=1 -> no stall.
- mem_busy held 10 cycles with a simultaneous load-use hazard -> pipe_freeze=1, hazard_source=1, mem_cnt=10, stall_err=1 after cycle 8; cnt_clr=1 -> counters=0, stall_err=0.
- JR_HAZARD_EN defined: opc_id=0, funct_id=6'b001000, rs_id=5, regwrite_idex=1, dst_idex=5 -> stall; undefined -> no stall.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: ID-stage hazard/stall controller for a 5-stage MIPS pipe with
// branch resolution in ID. Detects load-use and branch-operand hazards,
// freezes the pipe on data-memory wait, flushes IF/ID on taken branches,
// tracks stall state, counts events and flags overly long stalls.
// Optional build macro: JR_HAZARD_EN (jr treated as a branch consumer of rs).
module hazard_ctrl #(
    parameter int unsigned      REG_AW       = 5,
    parameter int unsigned      OPC_W        = 6,
    parameter logic [OPC_W-1:0] BEQ_OPC      = 6'b000100,
    parameter logic [OPC_W-1:0] BNE_OPC      = 6'b000101,
    parameter bit               BR_FWD_EXMEM = 1'b1,
    parameter int unsigned      CNT_W        = 16,
    parameter int unsigned      MAX_STALL    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OPC_W-1:0]  opc_id,
    input  logic [5:0]        funct_id,
    input  logic [REG_AW-1:0] rs_id,
    input  logic [REG_AW-1:0] rt_id,
    input  logic              rt_used_id,
    input  logic [REG_AW-1:0] dst_idex,
    input  logic              regwrite_idex,
    input  logic              memread_idex,
    input  logic [REG_AW-1:0] dst_exmem,
    input  logic              regwrite_exmem,
    input  logic              memread_exmem,
    input  logic              branch_taken_id,
    input  logic              mem_busy,
    input  logic              cnt_clr,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              hazard_source,
    output logic              pipe_freeze,
    output logic              ifid_flush,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  mem_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic              stall_err
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DSTALL = 2'd1,
        MWAIT  = 2'd2
    } state_t;

    localparam int unsigned     RL_W   = $clog2(MAX_STALL + 1);
    localparam logic [RL_W-1:0] RL_MAX = RL_W'(MAX_STALL);

    state_t          state_q;
    state_t          state_d;
    logic [RL_W-1:0] run_len;
    logic            stall_hit;

    logic is_jr;
    logic is_br;
    logic rt_chk;
    logic m_idex;
    logic m_exmem;
    logic load_use;
    logic br_haz;
    logic dstall;

`ifdef JR_HAZARD_EN
    assign is_jr = (opc_id == '0) && (funct_id == 6'b001000);
`else
    logic unused_funct;
    assign is_jr        = 1'b0;
    assign unused_funct = ^funct_id;
`endif

    // Decode the ID instruction and detect data hazards against ID/EX and EX/MEM
    always_comb begin
        is_br    = (opc_id == BEQ_OPC) || (opc_id == BNE_OPC) || is_jr;
        rt_chk   = rt_used_id && !is_jr;
        m_idex   = (dst_idex != '0) &&
                   ((dst_idex == rs_id) || (rt_chk && (dst_idex == rt_id)));
        m_exmem  = (dst_exmem != '0) &&
                   ((dst_exmem == rs_id) || (rt_chk && (dst_exmem == rt_id)));
        load_use = memread_idex && m_idex;
        br_haz   = is_br && ((regwrite_idex && m_idex) ||
                             (memread_exmem && m_exmem) ||
                             (!BR_FWD_EXMEM && regwrite_exmem && m_exmem));
        dstall   = load_use || br_haz;
    end

    // Pipeline controls (freeze > data stall > flush) and next FSM state
    always_comb begin
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        hazard_source = 1'b1;
        pipe_freeze   = 1'b0;
        ifid_flush    = 1'b0;
        state_d       = RUN;
        if (mem_busy) begin
            pipe_freeze = 1'b1;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            state_d     = MWAIT;
        end else if (dstall) begin
            pc_write      = 1'b0;
            ifid_write    = 1'b0;
            hazard_source = 1'b0;
            state_d       = DSTALL;
        end else if (branch_taken_id) begin
            ifid_flush = 1'b1;
        end
    end

    // State register and length of the current non-RUN run
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            run_len <= '0;
        end else begin
            state_q <= state_d;
            if (state_d == RUN)
                run_len <= '0;
            else if (run_len != RL_MAX)
                run_len <= run_len + RL_W'(1);
        end
    end

    // The edge that takes run_len to MAX_STALL is the one that raises stall_err
    assign stall_hit = (state_d != RUN) && (run_len >= RL_MAX - RL_W'(1));
    assign state     = state_q;

    // Saturating event counters and sticky stall timeout
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            stall_cnt <= '0;
            mem_cnt   <= '0;
            flush_cnt <= '0;
            stall_err <= 1'b0;
        end else begin
            if (dstall && !mem_busy && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (mem_busy && (mem_cnt != '1))
                mem_cnt <= mem_cnt + CNT_W'(1);
            if (ifid_flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
            if (stall_hit)
                stall_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scenario tasks plus randomized traffic checked against a
// rule-level reference model of hazard_ctrl (default and BR_FWD_EXMEM=0 builds).
module tb_hazard_ctrl;

    localparam int CNT_W     = 16;
    localparam int MAX_STALL = 8;
    localparam int CMAX      = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opc_id;
    logic [5:0]  funct_id;
    logic [4:0]  rs_id, rt_id, dst_idex, dst_exmem;
    logic        rt_used_id, regwrite_idex, memread_idex;
    logic        regwrite_exmem, memread_exmem;
    logic        branch_taken_id, mem_busy, cnt_clr;

    logic             pc_write, ifid_write, hazard_source, pipe_freeze, ifid_flush;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt, mem_cnt, flush_cnt;
    logic             stall_err;

    logic             pc_write0, ifid_write0, hazard_source0, pipe_freeze0, ifid_flush0;
    logic [1:0]       state0;
    logic [CNT_W-1:0] stall_cnt0, mem_cnt0, flush_cnt0;
    logic             stall_err0;

    logic [4:0] ctrl, ctrl0;
    assign ctrl  = {pc_write, ifid_write, hazard_source, pipe_freeze, ifid_flush};
    assign ctrl0 = {pc_write0, ifid_write0, hazard_source0, pipe_freeze0, ifid_flush0};

    int checks = 0;
    int errors = 0;

    int m_state, m_run, m_stall, m_mem, m_flush;
    bit m_err;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .REG_AW(5), .OPC_W(6), .BEQ_OPC(6'b000100), .BNE_OPC(6'b000101),
        .BR_FWD_EXMEM(1'b1), .CNT_W(CNT_W), .MAX_STALL(MAX_STALL)
    ) dut (
        .clk(clk), .rst(rst), .opc_id(opc_id), .funct_id(funct_id),
        .rs_id(rs_id), .rt_id(rt_id), .rt_used_id(rt_used_id),
        .dst_idex(dst_idex), .regwrite_idex(regwrite_idex), .memread_idex(memread_idex),
        .dst_exmem(dst_exmem), .regwrite_exmem(regwrite_exmem), .memread_exmem(memread_exmem),
        .branch_taken_id(branch_taken_id), .mem_busy(mem_busy), .cnt_clr(cnt_clr),
        .pc_write(pc_write), .ifid_write(ifid_write), .hazard_source(hazard_source),
        .pipe_freeze(pipe_freeze), .ifid_flush(ifid_flush), .state(state),
        .stall_cnt(stall_cnt), .mem_cnt(mem_cnt), .flush_cnt(flush_cnt), .stall_err(stall_err)
    );

    hazard_ctrl #(
        .REG_AW(5), .OPC_W(6), .BEQ_OPC(6'b000100), .BNE_OPC(6'b000101),
        .BR_FWD_EXMEM(1'b0), .CNT_W(CNT_W), .MAX_STALL(MAX_STALL)
    ) dut0 (
        .clk(clk), .rst(rst), .opc_id(opc_id), .funct_id(funct_id),
        .rs_id(rs_id), .rt_id(rt_id), .rt_used_id(rt_used_id),
        .dst_idex(dst_idex), .regwrite_idex(regwrite_idex), .memread_idex(memread_idex),
        .dst_exmem(dst_exmem), .regwrite_exmem(regwrite_exmem), .memread_exmem(memread_exmem),
        .branch_taken_id(branch_taken_id), .mem_busy(mem_busy), .cnt_clr(cnt_clr),
        .pc_write(pc_write0), .ifid_write(ifid_write0), .hazard_source(hazard_source0),
        .pipe_freeze(pipe_freeze0), .ifid_flush(ifid_flush0), .state(state0),
        .stall_cnt(stall_cnt0), .mem_cnt(mem_cnt0), .flush_cnt(flush_cnt0), .stall_err(stall_err0)
    );

    // ---------------- reference model ----------------
    function automatic bit jr_now();
`ifdef JR_HAZARD_EN
        return (opc_id == 6'd0) && (funct_id == 6'b001000);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit hits(logic [4:0] r);
        bit use_rt = rt_used_id && !jr_now();
        return (r != 5'd0) && ((r == rs_id) || (use_rt && (r == rt_id)));
    endfunction

    function automatic bit data_stall(bit fwd);
        bit br = (opc_id == 6'd4) || (opc_id == 6'd5) || jr_now();
        bit lu = memread_idex && hits(dst_idex);
        bit bh = br && ((regwrite_idex && hits(dst_idex)) ||
                        (memread_exmem && hits(dst_exmem)) ||
                        (!fwd && regwrite_exmem && hits(dst_exmem)));
        return lu || bh;
    endfunction

    // {pc_write, ifid_write, hazard_source, pipe_freeze, ifid_flush}
    function automatic logic [4:0] exp_ctrl(bit fwd);
        if (mem_busy)        return 5'b00110;
        if (data_stall(fwd)) return 5'b00000;
        if (branch_taken_id) return 5'b11101;
        return 5'b11100;
    endfunction

    task automatic model_edge();
        int nxt;
        logic [4:0] c;
        if (rst) begin
            m_state = 0; m_run = 0; m_stall = 0; m_mem = 0; m_flush = 0; m_err = 1'b0;
        end else begin
            nxt     = mem_busy ? 2 : (data_stall(1'b1) ? 1 : 0);
            c       = exp_ctrl(1'b1);
            m_state = nxt;
            m_run   = (nxt == 0) ? 0 : m_run + 1;
            if (cnt_clr) begin
                m_stall = 0; m_mem = 0; m_flush = 0; m_err = 1'b0;
            end else begin
                if (data_stall(1'b1) && !mem_busy && m_stall < CMAX) m_stall++;
                if (mem_busy && m_mem < CMAX) m_mem++;
                if (c[0] && m_flush < CMAX) m_flush++;
                if (m_run >= MAX_STALL) m_err = 1'b1;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        opc_id = '0; funct_id = '0; rs_id = '0; rt_id = '0; rt_used_id = 1'b0;
        dst_idex = '0; regwrite_idex = 1'b0; memread_idex = 1'b0;
        dst_exmem = '0; regwrite_exmem = 1'b0; memread_exmem = 1'b0;
        branch_taken_id = 1'b0; mem_busy = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle();
        rst = 1'b1; memread_idex = 1'b1; dst_idex = 5'd8; rs_id = 5'd8;
        #1;
        checks++;
        if (ctrl !== 5'b00000) begin
            errors++; $display("FAIL reset_comb ctrl got %b exp %b", ctrl, 5'b00000);
        end
        step();
        checks++;
        if ({state, stall_cnt, mem_cnt, flush_cnt, stall_err} !== '0) begin
            errors++;
            $display("FAIL reset_regs got st=%0d s=%0d m=%0d f=%0d e=%0d exp all 0",
                     state, stall_cnt, mem_cnt, flush_cnt, stall_err);
        end
        rst = 1'b0;
        step();
        checks++;
        if (state !== 2'd1 || stall_cnt !== 16'd1) begin
            errors++; $display("FAIL reset_prestall got st=%0d s=%0d exp st=1 s=1", state, stall_cnt);
        end
        rst = 1'b1;
        step();
        checks++;
        if (state !== 2'd0 || stall_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_midstall got st=%0d s=%0d exp st=0 s=0", state, stall_cnt);
        end
        rst = 1'b0;
        idle();
    endtask

    task automatic test_load_use();
        do_reset();
        memread_idex = 1'b1; dst_idex = 5'd8; rs_id = 5'd8;
        #1;
        checks++;
        if (ctrl !== 5'b00000) begin
            errors++; $display("FAIL load_use_ctrl got %b exp %b", ctrl, 5'b00000);
        end
        step();
        checks++;
        if (state !== 2'd1 || stall_cnt !== 16'd1) begin
            errors++; $display("FAIL load_use_regs got st=%0d s=%0d exp st=1 s=1", state, stall_cnt);
        end
        idle();
        rt_used_id = 1'b1; rt_id = 5'd8; memread_idex = 1'b1; dst_idex = 5'd8; rs_id = 5'd3;
        #1;
        checks++;
        if (ctrl !== 5'b00000) begin
            errors++; $display("FAIL load_use_rt got %b exp %b", ctrl, 5'b00000);
        end
        rt_used_id = 1'b0;
        #1;
        checks++;
        if (ctrl !== 5'b11100) begin
            errors++; $display("FAIL load_use_rt_unused got %b exp %b", ctrl, 5'b11100);
        end
        idle();
        step();
    endtask

    task automatic test_zero_reg();
        do_reset();
        memread_idex = 1'b1; dst_idex = 5'd0; rs_id = 5'd0; rt_id = 5'd0; rt_used_id = 1'b1;
        opc_id = 6'd4; regwrite_idex = 1'b1; memread_exmem = 1'b1; dst_exmem = 5'd0;
        #1;
        checks++;
        if (ctrl !== 5'b11100) begin
            errors++; $display("FAIL zero_reg_ctrl got %b exp %b", ctrl, 5'b11100);
        end
        step();
        checks++;
        if (state !== 2'd0 || stall_cnt !== 16'd0) begin
            errors++; $display("FAIL zero_reg_regs got st=%0d s=%0d exp st=0 s=0", state, stall_cnt);
        end
        idle();
    endtask

    task automatic test_load_beq();
        do_reset();
        opc_id = 6'd4; rs_id = 5'd9; rt_id = 5'd0; rt_used_id = 1'b1; branch_taken_id = 1'b1;
        memread_idex = 1'b1; regwrite_idex = 1'b1; dst_idex = 5'd9;
        #1;
        checks++;
        if (ctrl !== 5'b00000) begin
            errors++; $display("FAIL lbeq_stall1 got %b exp %b", ctrl, 5'b00000);
        end
        step();
        memread_idex = 1'b0; regwrite_idex = 1'b0; dst_idex = 5'd0;
        memread_exmem = 1'b1; regwrite_exmem = 1'b1; dst_exmem = 5'd9;
        #1;
        checks++;
        if (ctrl !== 5'b00000) begin
            errors++; $display("FAIL lbeq_stall2 got %b exp %b", ctrl, 5'b00000);
        end
        step();
        checks++;
        if (stall_cnt !== 16'd2 || flush_cnt !== 16'd0) begin
            errors++; $display("FAIL lbeq_cnt got s=%0d f=%0d exp s=2 f=0", stall_cnt, flush_cnt);
        end
        memread_exmem = 1'b0; regwrite_exmem = 1'b0; dst_exmem = 5'd0;
        #1;
        checks++;
        if (ctrl !== 5'b11101) begin
            errors++; $display("FAIL lbeq_flush got %b exp %b", ctrl, 5'b11101);
        end
        step();
        idle();
        #1;
        checks++;
        if (ctrl !== 5'b11100 || flush_cnt !== 16'd1 || state !== 2'd0) begin
            errors++;
            $display("FAIL lbeq_after got ctrl=%b f=%0d st=%0d exp ctrl=11100 f=1 st=0",
                     ctrl, flush_cnt, state);
        end
        step();
    endtask

    task automatic test_exmem_branch();
        do_reset();
        opc_id = 6'd4; rs_id = 5'd4; rt_id = 5'd0; rt_used_id = 1'b1;
        regwrite_exmem = 1'b1; dst_exmem = 5'd4;
        #1;
        checks++;
        if (ctrl !== 5'b11100 || ctrl0 !== 5'b00000) begin
            errors++;
            $display("FAIL exmem_alu got fwd1=%b fwd0=%b exp fwd1=11100 fwd0=00000", ctrl, ctrl0);
        end
        opc_id = 6'd5; memread_exmem = 1'b1;
        #1;
        checks++;
        if (ctrl !== 5'b00000 || ctrl0 !== 5'b00000) begin
            errors++;
            $display("FAIL exmem_load got fwd1=%b fwd0=%b exp both 00000", ctrl, ctrl0);
        end
        opc_id = 6'd0;
        #1;
        checks++;
        if (ctrl !== 5'b11100 || ctrl0 !== 5'b11100) begin
            errors++;
            $display("FAIL exmem_nonbranch got fwd1=%b fwd0=%b exp both 11100", ctrl, ctrl0);
        end
        idle();
        step();
    endtask

    task automatic test_mem_freeze();
        do_reset();
        mem_busy = 1'b1; memread_idex = 1'b1; dst_idex = 5'd8; rs_id = 5'd8;
        for (int i = 1; i <= 10; i++) begin
            #1;
            checks++;
            if (ctrl !== 5'b00110) begin
                errors++; $display("FAIL freeze_ctrl cyc=%0d got %b exp %b", i, ctrl, 5'b00110);
            end
            step();
            checks++;
            if (stall_err !== (i >= MAX_STALL) || state !== 2'd2) begin
                errors++;
                $display("FAIL freeze_err cyc=%0d got e=%0d st=%0d exp e=%0d st=2",
                         i, stall_err, state, (i >= MAX_STALL));
            end
        end
        checks++;
        if (mem_cnt !== 16'd10 || stall_cnt !== 16'd0) begin
            errors++; $display("FAIL freeze_cnt got m=%0d s=%0d exp m=10 s=0", mem_cnt, stall_cnt);
        end
        cnt_clr = 1'b1;
        step();
        checks++;
        if (mem_cnt !== 16'd0 || stall_err !== 1'b0) begin
            errors++; $display("FAIL cnt_clr got m=%0d e=%0d exp m=0 e=0", mem_cnt, stall_err);
        end
        idle();
        step();
        checks++;
        if ({state, stall_cnt, mem_cnt, flush_cnt, stall_err} !== '0) begin
            errors++;
            $display("FAIL clr_after got st=%0d s=%0d m=%0d f=%0d e=%0d exp all 0",
                     state, stall_cnt, mem_cnt, flush_cnt, stall_err);
        end
    endtask

    task automatic test_jr();
        logic [4:0] want;
`ifdef JR_HAZARD_EN
        want = 5'b00000;
`else
        want = 5'b11100;
`endif
        do_reset();
        opc_id = 6'd0; funct_id = 6'b001000; rs_id = 5'd5; rt_id = 5'd0; rt_used_id = 1'b1;
        regwrite_idex = 1'b1; dst_idex = 5'd5;
        #1;
        checks++;
        if (ctrl !== want) begin
            errors++; $display("FAIL jr_hazard got %b exp %b", ctrl, want);
        end
        idle();
        step();
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            idle();
            if (i % 2 == 0) begin
                memread_idex = 1'b1; dst_idex = 5'd7; rs_id = 5'd7;
            end else begin
                opc_id = 6'd5; branch_taken_id = 1'b1;
            end
            #1;
            checks++;
            if (ctrl !== exp_ctrl(1'b1)) begin
                errors++; $display("FAIL b2b_ctrl cyc=%0d got %b exp %b", i, ctrl, exp_ctrl(1'b1));
            end
            step();
        end
        checks++;
        if (stall_cnt !== 16'd4 || flush_cnt !== 16'd4 || state !== 2'd0) begin
            errors++;
            $display("FAIL b2b_cnt got s=%0d f=%0d st=%0d exp s=4 f=4 st=0", stall_cnt, flush_cnt, state);
        end
        idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0:       opc_id = 6'd0;
                1:       opc_id = 6'd4;
                2:       opc_id = 6'd5;
                default: opc_id = 6'($urandom_range(0, 63));
            endcase
            funct_id        = ($urandom_range(0, 3) == 0) ? 6'b001000 : 6'($urandom_range(0, 63));
            rs_id           = 5'($urandom_range(0, 3));
            rt_id           = 5'($urandom_range(0, 3));
            dst_idex        = 5'($urandom_range(0, 3));
            dst_exmem       = 5'($urandom_range(0, 3));
            rt_used_id      = 1'($urandom_range(0, 1));
            regwrite_idex   = 1'($urandom_range(0, 1));
            memread_idex    = ($urandom_range(0, 3) == 0);
            regwrite_exmem  = 1'($urandom_range(0, 1));
            memread_exmem   = ($urandom_range(0, 3) == 0);
            branch_taken_id = ($urandom_range(0, 2) == 0);
            mem_busy        = ($urandom_range(0, 4) == 0);
            cnt_clr         = ($urandom_range(0, 19) == 0);
            rst             = ($urandom_range(0, 49) == 0);
            #1;
            checks++;
            if (ctrl !== exp_ctrl(1'b1) || ctrl0 !== exp_ctrl(1'b0)) begin
                errors++;
                $display("FAIL rand_ctrl cyc=%0d got %b/%b exp %b/%b",
                         i, ctrl, ctrl0, exp_ctrl(1'b1), exp_ctrl(1'b0));
            end
            step();
            checks++;
            if ({state, stall_cnt, mem_cnt, flush_cnt, stall_err} !==
                {2'(m_state), CNT_W'(m_stall), CNT_W'(m_mem), CNT_W'(m_flush), m_err}) begin
                errors++;
                $display("FAIL rand_regs cyc=%0d got st=%0d s=%0d m=%0d f=%0d e=%0d exp st=%0d s=%0d m=%0d f=%0d e=%0d",
                         i, state, stall_cnt, mem_cnt, flush_cnt, stall_err,
                         m_state, m_stall, m_mem, m_flush, m_err);
            end
        end
        rst = 1'b0;
        idle();
    endtask

    task automatic test_saturation();
        do_reset();
        mem_busy = 1'b1;
        for (int i = 0; i < CMAX + 2; i++) step();
        checks++;
        if (mem_cnt !== CNT_W'(CMAX) || mem_cnt !== CNT_W'(m_mem) || stall_err !== 1'b1) begin
            errors++;
            $display("FAIL mem_sat got m=%0d e=%0d exp m=%0d e=1", mem_cnt, stall_err, CMAX);
        end
        idle();
        step();
    endtask

    initial begin
        rst = 1'b0;
        idle();
        test_reset();
        test_load_use();
        test_zero_reg();
        test_load_beq();
        test_exmem_branch();
        test_mem_freeze();
        test_jr();
        test_back_to_back();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
